// File: rtl/i2c_wb_xfer_if.sv
// Request/response handshake and Wishbone master signals for the i2c_wb_xfer sequencer.
// Signal names match the original flat port list so existing hookups translate one-to-one.
interface i2c_wb_xfer_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic       req_rnw;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i;

    modport master (
        input  req_valid, req_addr, req_rnw, req_data, wb_dat_i, wb_ack_i,
        output req_ready, rsp_valid, rsp_data, rsp_nack, busy,
               wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output req_valid, req_addr, req_rnw, req_data, wb_dat_i, wb_ack_i,
        input  req_ready, rsp_valid, rsp_data, rsp_nack, busy,
               wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/i2c_wb_xfer.sv
// Wishbone master driving an OpenCores i2c_master_top: one-time prescaler/enable setup,
// then single-byte I2C read/write transfers with SR polling and ACK/NACK reporting.
module i2c_wb_xfer #(
    parameter logic [15:0] PRESCALE = 16'h0063,
    parameter int unsigned POLL_GAP = 4
) (
    input logic          CLOCK_50,
    input logic          RESET_N,
    i2c_wb_xfer_if.master bus
);

    typedef enum logic [3:0] {
        INIT_PRL, INIT_PRH, INIT_CTR, IDLE, TX_A, CR_A, POLL_A, CR_STO,
        POLL_S, TX_D, CR_D, CR_R, POLL_D, RD_RXR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [2:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [6:0]  addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  rdat_q, rdat_d;
    logic        nack_q, nack_d;
    logic [15:0] gap_q, gap_d;

    logic        acc_en, acc_we, is_poll;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_dat;
    logic        done, tip, rxack;

    // Register access implied by each state
    always_comb begin
        acc_en  = 1'b1;
        acc_we  = 1'b1;
        acc_adr = '0;
        acc_dat = '0;
        is_poll = 1'b0;
        case (state_q)
            INIT_PRL: begin acc_adr = 3'd0; acc_dat = PRESCALE[7:0];  end
            INIT_PRH: begin acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; end
            INIT_CTR: begin acc_adr = 3'd2; acc_dat = 8'h80;          end
            TX_A:     begin acc_adr = 3'd3; acc_dat = {addr_q, rnw_q}; end
            CR_A:     begin acc_adr = 3'd4; acc_dat = 8'h90;          end
            CR_STO:   begin acc_adr = 3'd4; acc_dat = 8'h40;          end
            TX_D:     begin acc_adr = 3'd3; acc_dat = wdat_q;         end
            CR_D:     begin acc_adr = 3'd4; acc_dat = 8'h50;          end
            CR_R:     begin acc_adr = 3'd4; acc_dat = 8'h68;          end
            POLL_A, POLL_S, POLL_D: begin
                acc_we  = 1'b0;
                acc_adr = 3'd4;
                is_poll = 1'b1;
            end
            RD_RXR:   begin acc_we = 1'b0; acc_adr = 3'd3;            end
            default:  acc_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        nack_d  = nack_q;
        gap_d   = gap_q;
        done    = stb_q & bus.wb_ack_i;
        tip     = bus.wb_dat_i[1];
        rxack   = bus.wb_dat_i[7];

        if (gap_q != '0)
            gap_d = gap_q - 16'd1;

        // Strobe rises only from a low cycle, so consecutive accesses always get a gap
        if (acc_en && !stb_q && gap_q == '0) begin
            stb_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end
        if (done)
            stb_d = 1'b0;
        if (done && is_poll && tip)
            gap_d = 16'(POLL_GAP);

        case (state_q)
            INIT_PRL: if (done) state_d = INIT_PRH;
            INIT_PRH: if (done) state_d = INIT_CTR;
            INIT_CTR: if (done) state_d = IDLE;
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr;
                rnw_d   = bus.req_rnw;
                wdat_d  = bus.req_data;
                nack_d  = 1'b0;
                state_d = TX_A;
            end
            TX_A:   if (done) state_d = CR_A;
            CR_A:   if (done) state_d = POLL_A;
            POLL_A: if (done && !tip) begin
                if (rxack) begin
                    nack_d  = 1'b1;
                    state_d = CR_STO;
                end else begin
                    state_d = rnw_q ? CR_R : TX_D;
                end
            end
            CR_STO: if (done) state_d = POLL_S;
            POLL_S: if (done && !tip) state_d = RESP;
            TX_D:   if (done) state_d = CR_D;
            CR_D:   if (done) state_d = POLL_D;
            CR_R:   if (done) state_d = POLL_D;
            POLL_D: if (done && !tip) begin
                if (!rnw_q)
                    nack_d = rxack;
                state_d = rnw_q ? RD_RXR : RESP;
            end
            RD_RXR: if (done) begin
                rdat_d  = bus.wb_dat_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = INIT_PRL;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= INIT_PRL;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            nack_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            nack_q  <= nack_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_cyc_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rdat_q;
    assign bus.rsp_nack  = nack_q;

endmodule

// File: tb/tb_i2c_wb_xfer.sv
// Bench for i2c_wb_xfer: behavioural i2c_master_top register model with one slave,
// expected register-access lists built per request, randomized timing and requests.
module tb_i2c_wb_xfer;

    localparam int unsigned POLL_GAP = 4;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;

    i2c_wb_xfer_if bus ();

    i2c_wb_xfer #(.PRESCALE(16'h0063), .POLL_GAP(POLL_GAP)) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Core/slave model knobs
    int          ack_dly   = 0;
    int          tip_polls = 2;
    bit          spur_en   = 1'b0;
    bit          data_nack = 1'b0;
    logic [6:0]  slave_addr = 7'h51;
    logic [7:0]  slave_byte = 8'h00;

    // Access log entries: {we, adr, wdata-or-0}
    logic [11:0] acc_q[$];
    logic [11:0] exp_q[$];
    logic        exp_nack = 1'b0;
    logic [7:0]  exp_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    // i2c_master_top register model and Wishbone slave responder
    initial begin
        int          cnt, low_cnt, tip_cnt;
        bit          stb_prev, last_poll, first;
        logic [11:0] cur, held;
        logic [7:0]  txr, rxr, sr;
        bit          rxack_r;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'h00;
        cnt = 0; low_cnt = 0; tip_cnt = 0;
        stb_prev = 1'b0; last_poll = 1'b0; first = 1'b1;
        held = '0; txr = '0; rxr = '0; rxack_r = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (!RESET_N) begin
                bus.wb_ack_i = 1'b0;
                cnt = 0; low_cnt = 0; tip_cnt = 0;
                stb_prev = 1'b0; last_poll = 1'b0; first = 1'b1;
                continue;
            end
            check("cyc_eq_stb", bus.wb_cyc_o, bus.wb_stb_o);
            cur = {bus.wb_we_o, bus.wb_adr_o, bus.wb_we_o ? bus.wb_dat_o : 8'h00};
            if (bus.wb_stb_o && !stb_prev) begin
                if (!first) begin
                    check("stb_low_gap", low_cnt >= 1, 1);
                    if (last_poll && cur == 12'h400)
                        check("poll_spacing", low_cnt >= int'(POLL_GAP), 1);
                end
                held  = {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o};
                first = 1'b0;
            end else if (bus.wb_stb_o) begin
                check("hold_stable", {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}, held);
            end

            if (bus.wb_ack_i) begin
                bus.wb_ack_i = 1'b0;
                cnt = 0;
            end else if (bus.wb_stb_o) begin
                if (cnt >= ack_dly) begin
                    cnt = 0;
                    bus.wb_dat_i = 8'($urandom);
                    if (bus.wb_we_o) begin
                        if (bus.wb_adr_o == 3'd3) txr = bus.wb_dat_o;
                        if (bus.wb_adr_o == 3'd4) begin
                            tip_cnt = tip_polls;
                            if (bus.wb_dat_o[7])
                                rxack_r = (txr[7:1] != slave_addr);
                            else if (bus.wb_dat_o == 8'h50)
                                rxack_r = data_nack;
                            else if (bus.wb_dat_o == 8'h68) begin
                                rxr     = slave_byte;
                                rxack_r = 1'($urandom);
                            end
                        end
                    end else if (bus.wb_adr_o == 3'd4) begin
                        sr = 8'($urandom);
                        if (tip_cnt > 0) begin
                            tip_cnt--;
                            sr[1] = 1'b1;
                        end else begin
                            sr[1] = 1'b0;
                            sr[7] = rxack_r;
                        end
                        bus.wb_dat_i = sr;
                    end else if (bus.wb_adr_o == 3'd3) begin
                        bus.wb_dat_i = rxr;
                    end
                    bus.wb_ack_i = 1'b1;
                    acc_q.push_back(cur);
                    last_poll = (cur == 12'h400);
                end else begin
                    cnt++;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = 8'($urandom);
            end

            if (bus.wb_stb_o) low_cnt = 0;
            else low_cnt++;
            stb_prev = bus.wb_stb_o;
        end
    end

    task automatic push_polls();
        repeat (tip_polls + 1) exp_q.push_back(12'h400);
    endtask

    task automatic expect_init();
        exp_q.push_back(12'h863);
        exp_q.push_back(12'h900);
        exp_q.push_back(12'hA80);
    endtask

    // Expected register traffic and outcome of one request, from the core's programming model
    task automatic expect_req(input logic [6:0] a, input bit rnw, input logic [7:0] d);
        exp_q.push_back({4'hB, a, rnw});
        exp_q.push_back(12'hC90);
        push_polls();
        if (a != slave_addr) begin
            exp_q.push_back(12'hC40);
            push_polls();
            exp_nack = 1'b1;
        end else if (!rnw) begin
            exp_q.push_back({4'hB, d});
            exp_q.push_back(12'hC50);
            push_polls();
            exp_nack = data_nack;
        end else begin
            exp_q.push_back(12'hC68);
            push_polls();
            exp_q.push_back(12'h300);
            exp_nack = 1'b0;
            exp_data = slave_byte;
        end
    endtask

    task automatic compare_acc();
        check("acc_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            check("acc_seq", acc_q[i], exp_q[i]);
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_rsp(input bit jitter);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 40000) begin
            if (jitter) begin
                bus.req_valid = 1'($urandom);
                bus.req_addr  = 7'($urandom);
                bus.req_rnw   = 1'($urandom);
                bus.req_data  = 8'($urandom);
            end
            @(negedge CLOCK_50);
            n++;
        end
        bus.req_valid = 1'b0;
        check("rsp_seen", bus.rsp_valid, 1);
        check("rsp_nack", bus.rsp_nack, exp_nack);
        check("rsp_data", bus.rsp_data, exp_data);
        @(negedge CLOCK_50);
        check("rsp_pulse", bus.rsp_valid, 0);
        check("idle_ready", bus.req_ready, 1);
        check("idle_busy", bus.busy, 0);
        compare_acc();
    endtask

    task automatic run_req(input logic [6:0] a, input bit rnw, input logic [7:0] d);
        int n;
        expect_req(a, rnw, d);
        @(negedge CLOCK_50);
        n = 0;
        while (!bus.req_ready && n < 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_before_req", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_rnw   = rnw;
        bus.req_data  = d;
        @(negedge CLOCK_50);
        check("ready_drops", bus.req_ready, 0);
        check("busy_set", bus.busy, 1);
        wait_rsp(1'b1);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_rnw   = 1'b0;
        bus.req_data  = '0;

        #5;
        check("rst_stb", bus.wb_stb_o, 0);
        check("rst_cyc", bus.wb_cyc_o, 0);
        check("rst_we", bus.wb_we_o, 0);
        check("rst_adr", bus.wb_adr_o, 0);
        check("rst_dat", bus.wb_dat_o, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_nack", bus.rsp_nack, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_busy", bus.busy, 1);

        repeat (3) @(negedge CLOCK_50);
        #2 RESET_N = 1'b1;
        expect_init();
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("init_ready", bus.req_ready, 1);
        check("init_busy", bus.busy, 0);
        compare_acc();

        // Directed: write ACKed, read, address NACK, slow core
        slave_byte = 8'h5B;
        run_req(7'h51, 1'b0, 8'hAC);
        run_req(7'h51, 1'b1, 8'h00);
        run_req(7'h22, 1'b0, 8'h11);
        data_nack = 1'b1;
        run_req(7'h51, 1'b0, 8'h3D);
        data_nack = 1'b0;
        ack_dly   = 5;
        tip_polls = 200;
        run_req(7'h51, 1'b0, 8'hE7);

        for (int i = 0; i < 24; i++) begin
            logic [6:0] a;
            ack_dly    = $urandom_range(0, 3);
            tip_polls  = $urandom_range(0, 5);
            spur_en    = 1'($urandom);
            data_nack  = 1'($urandom);
            slave_byte = 8'($urandom);
            a = ($urandom_range(0, 2) != 0) ? slave_addr : 7'($urandom);
            run_req(a, 1'($urandom), 8'($urandom));
        end

        // Reset during the data-phase poll, with a read request held throughout
        spur_en   = 1'b0;
        ack_dly   = 1;
        tip_polls = 50;
        data_nack = 1'b0;
        @(negedge CLOCK_50);
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'h51;
        bus.req_rnw   = 1'b0;
        bus.req_data  = 8'h3C;
        @(negedge CLOCK_50);
        bus.req_valid = 1'b0;
        n = 0;
        while (!(acc_q.size() > 0 && acc_q[$] == 12'hC50) && n < 5000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("reached_poll_d", acc_q.size() > 0 && acc_q[$] == 12'hC50, 1);
        repeat (20) @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #3;
        RESET_N       = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'h51;
        bus.req_rnw   = 1'b1;
        bus.req_data  = 8'h00;
        #1;
        check("async_stb", bus.wb_stb_o, 0);
        check("async_cyc", bus.wb_cyc_o, 0);
        check("async_busy", bus.busy, 1);
        check("async_ready", bus.req_ready, 0);
        check("async_rsp_data", bus.rsp_data, 0);
        repeat (3) @(negedge CLOCK_50);
        acc_q.delete();
        exp_q.delete();
        exp_data   = 8'h00;
        tip_polls  = 3;
        slave_byte = 8'hC4;
        expect_init();
        expect_req(7'h51, 1'b1, 8'h00);
        #2 RESET_N = 1'b1;
        wait_rsp(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
